rng_mem_logger: RTL and testbench

Writer-side companion to the random generator's memory reader. It accepts a stream of 16-bit words over a valid/ready handshake, for example rng_out samples, buffers them in a small FIFO, and writes them into the shared mem block at consecutive addresses from a programmable base. It drives the mem write port (address, wr_en, mem_data_in), so the generator can later read back seeds or logs the logger has stored.

---
 rtl/rng_mem_logger_if.sv | 27 ++
 rtl/rng_mem_logger.sv | 97 +++++++++
 tb/tb_rng_mem_logger.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_mem_logger_if.sv
// rng_mem_logger_if: run control, input stream and mem write/read port of the logger
interface rng_mem_logger_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0] len;
  logic [DATA_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [ADDR_W-1:0] address;
  logic wr_en;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic busy;
  logic done;
  logic error;
  modport master (
    output start, base_addr, len, in_data, in_valid, mem_data_out,
    input in_ready, address, wr_en, mem_data_in, busy, done, error
  );
  modport slave (
    input start, base_addr, len, in_data, in_valid, mem_data_out,
    output in_ready, address, wr_en, mem_data_in, busy, done, error
  );
endinterface

// File: rtl/rng_mem_logger.sv
// rng_mem_logger: buffers a valid/ready word stream and writes it to mem from a base address
// Optional READBACK_VERIFY_EN: read back every written word and flag mismatches on error.
module rng_mem_logger #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic clock,
  input logic nreset,
  rng_mem_logger_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] ONE = 1;
`ifdef READBACK_VERIFY_EN
  typedef enum logic [2:0] {IDLE, RUN, DONE, VERIFY, CHECK} state_t;
  logic error_q;
  assign bus.error = error_q;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  logic unused_rd;
  assign unused_rd = ^bus.mem_data_out;
  assign bus.error = 1'b0;
`endif
  state_t state;
  logic [DATA_W-1:0] fifo [FIFO_DEPTH];
  logic [PW:0] rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] base, addr_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0] len_q, accepted, written;
  logic empty, full, active, push, pop, last;
  // Extra pointer bit tells full from empty when the indices match
  assign empty = rd_ptr == wr_ptr;
  assign full = (rd_ptr[PW] != wr_ptr[PW]) && (rd_ptr[PW-1:0] == wr_ptr[PW-1:0]);
  assign active = state != IDLE && state != DONE;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = state == RUN && !empty;
  assign last = written + 16'd1 == len_q;
  assign bus.in_ready = active && !full && accepted < len_q;
  assign bus.wr_en = pop;
  // Write port is live while the head word is committed, otherwise it holds the last write
  assign bus.address = pop ? base + ADDR_W'(written) : addr_q;
  assign bus.mem_data_in = pop ? fifo[rd_ptr[PW-1:0]] : data_q;
  assign bus.busy = active;
  assign bus.done = state == DONE;
  // FIFO, counters and run control
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      accepted <= '0;
      written <= '0;
      base <= '0;
      len_q <= '0;
      addr_q <= '0;
      data_q <= '0;
`ifdef READBACK_VERIFY_EN
      error_q <= 1'b0;
`endif
    end else begin
      if (push) begin
        fifo[wr_ptr[PW-1:0]] <= bus.in_data;
        wr_ptr <= wr_ptr + ONE;
        accepted <= accepted + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE;
        written <= written + 16'd1;
        addr_q <= bus.address;
        data_q <= bus.mem_data_in;
      end
      case (state)
        IDLE: if (bus.start) begin
          base <= bus.base_addr;
          len_q <= bus.len;
          accepted <= '0;
          written <= '0;
`ifdef READBACK_VERIFY_EN
          error_q <= 1'b0;
`endif
          state <= bus.len == 16'd0 ? DONE : RUN;
        end
`ifdef READBACK_VERIFY_EN
        RUN: if (pop) state <= VERIFY;
        VERIFY: state <= CHECK;
        CHECK: begin
          if (bus.mem_data_out != data_q) error_q <= 1'b1;
          state <= written == len_q ? DONE : RUN;
        end
`else
        RUN: if (pop && last) state <= DONE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rng_mem_logger.sv
// tb_rng_mem_logger: directed stimulus with a cycle-level reference model and literal checks
module tb_rng_mem_logger;
  localparam int DEPTH = 4;
`ifdef READBACK_VERIFY_EN
  localparam int SPACING = 3;
`else
  localparam int SPACING = 1;
`endif
  logic clock = 0;
  logic nreset = 0;
  bit chk_en = 0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always #5 clock = ~clock;

  rng_mem_logger_if itf ();
  rng_mem_logger #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .nreset(nreset), .bus(itf.slave)
  );

  logic [15:0] mem [65536];
  bit corrupt = 0;
  logic [15:0] corrupt_addr = 0;
  // Memory with one-cycle read latency and an optional bit flip on one read address
  always @(posedge clock) begin
    if (itf.wr_en) mem[itf.address] <= itf.mem_data_in;
    itf.mem_data_out <= mem[itf.address] ^ ((corrupt && itf.address == corrupt_addr) ? 16'h8000 : 16'h0000);
  end

  logic [15:0] wlog [$];
  int wcyc [$];
  always @(posedge clock) cyc <= cyc + 1;
  // Record every write address together with its cycle
  always @(negedge clock) if (itf.wr_en) begin
    wlog.push_back(itf.address);
    wcyc.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words pending = accepted - written, held in a queue
  bit m_run = 0, m_done = 0, m_err = 0;
  int m_ph = 0;
  logic [15:0] m_base = 0, m_len = 0, m_acc = 0, m_wr = 0, m_addr = 0, m_data = 0;
  logic [15:0] m_q [$];
  function automatic bit e_rdy();
    return m_run && m_q.size() < DEPTH && m_acc < m_len;
  endfunction
  function automatic bit e_wen();
    return m_run && m_ph == 0 && m_q.size() > 0;
  endfunction

  // Advance the model at each rising edge using the bench's own inputs
  always @(posedge clock) begin
    bit rdy, wen;
    rdy = e_rdy();
    wen = e_wen();
    if (!nreset) begin
      m_run = 0; m_done = 0; m_err = 0; m_ph = 0;
      m_acc = 0; m_wr = 0; m_addr = 0; m_data = 0;
      m_q.delete();
    end else if (m_done) m_done = 0;
    else if (!m_run) begin
      if (itf.start) begin
        m_base = itf.base_addr; m_len = itf.len; m_acc = 0; m_wr = 0; m_err = 0; m_ph = 0;
        m_q.delete();
        if (itf.len == 0) m_done = 1; else m_run = 1;
      end
    end else begin
      if (wen) begin
        m_addr = m_base + m_wr;
        m_data = m_q.pop_front();
        m_wr++;
      end
`ifdef READBACK_VERIFY_EN
      if (m_ph == 2) begin
        if (itf.mem_data_out !== m_data) m_err = 1;
        m_ph = 0;
        if (m_wr == m_len) begin m_run = 0; m_done = 1; end
      end else if (m_ph == 1) m_ph = 2;
      else if (wen) m_ph = 1;
`else
      if (wen && m_wr == m_len) begin m_run = 0; m_done = 1; end
`endif
      if (itf.in_valid && rdy) begin
        m_q.push_back(itf.in_data);
        m_acc++;
      end
    end
  end

  // Compare every DUT output with the model each cycle
  always @(negedge clock) if (chk_en) begin
    bit wen;
    logic [15:0] ea, ed;
    wen = e_wen();
    ea = m_addr;
    ed = m_data;
    if (wen) begin
      ea = m_base + m_wr;
      ed = m_q[0];
    end
    check("in_ready", itf.in_ready, e_rdy());
    check("wr_en", itf.wr_en, wen);
    check("address", itf.address, ea);
    check("mem_data_in", itf.mem_data_in, ed);
    check("busy", itf.busy, m_run);
    check("done", itf.done, m_done);
    check("error", itf.error, m_err);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go(input logic [15:0] b, input logic [15:0] l);
    itf.base_addr = b;
    itf.len = l;
    itf.start = 1;
    tick();
    itf.start = 0;
  endtask

  task automatic send(input logic [15:0] d, input bit gap);
    int t = 0;
    itf.in_data = d;
    itf.in_valid = 1;
    while (!itf.in_ready && t < 200) begin
      tick();
      t++;
    end
    check("send accepted in time", t < 200, 1);
    tick();
    itf.in_valid = 0;
    if (gap) tick();
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!itf.done && t < 300) begin
      tick();
      t++;
    end
    check({name, " done seen"}, t < 300, 1);
    tick();
  endtask

  initial begin
    itf.start = 0; itf.base_addr = 0; itf.len = 0; itf.in_data = 0; itf.in_valid = 0;
    nreset = 0;
    tick();
    chk_en = 1;
    tick();
    check("rst wr_en", itf.wr_en, 0);
    check("rst in_ready", itf.in_ready, 0);
    check("rst address", itf.address, 0);
    check("rst mem_data_in", itf.mem_data_in, 0);
    check("rst busy", itf.busy, 0);
    check("rst done", itf.done, 0);
    check("rst error", itf.error, 0);
    nreset = 1;
    tick();

    wlog.delete(); wcyc.delete();
    go(16'h0010, 16'd3);
    send(16'hA001, 0); send(16'hA002, 0); send(16'hA003, 0);
    itf.in_data = 16'hA004;
    itf.in_valid = 1;
    check("basic 4th refused", itf.in_ready, 0);
    wait_done("basic");
    itf.in_valid = 0;
    check("basic count", wlog.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("basic addr", wlog[i], 16'h0010 + i);
      check("basic mem", mem[16'h0010 + i], 16'hA001 + i);
    end
    check("basic spacing", wcyc[2] - wcyc[0], 2 * SPACING);
    check("basic error", itf.error, 0);

    wlog.delete(); wcyc.delete();
    go(16'h0100, 16'd8);
    for (int i = 0; i < 8; i++) send(16'hB000 + 16'(i) * 16'h0111, 1);
    wait_done("bubble");
    check("bubble count", wlog.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("bubble addr", wlog[i], 16'h0100 + i);
      check("bubble mem", mem[16'h0100 + i], 16'hB000 + 16'(i) * 16'h0111);
    end

    wlog.delete(); wcyc.delete();
    go(16'hFFFE, 16'd4);
    for (int i = 0; i < 4; i++) send(16'hC000 + 16'(i), 0);
    wait_done("wrap");
    check("wrap count", wlog.size(), 4);
    check("wrap addr0", wlog[0], 16'hFFFE);
    check("wrap addr1", wlog[1], 16'hFFFF);
    check("wrap addr2", wlog[2], 16'h0000);
    check("wrap addr3", wlog[3], 16'h0001);
    check("wrap mem", mem[16'h0001], 16'hC003);

    wlog.delete(); wcyc.delete();
    go(16'h0700, 16'd0);
    check("zero len done", itf.done, 1);
    tick();
    check("zero len done gone", itf.done, 0);
    check("zero len no writes", wlog.size(), 0);

    wlog.delete(); wcyc.delete();
    go(16'h0300, 16'd4);
    send(16'hD000, 0); send(16'hD001, 0);
    itf.base_addr = 16'h0200; itf.len = 16'd2; itf.start = 1;
    tick();
    itf.start = 0;
    send(16'hD002, 0); send(16'hD003, 0);
    wait_done("busy start");
    check("busy start count", wlog.size(), 4);
    for (int i = 0; i < 4; i++) check("busy start addr", wlog[i], 16'h0300 + i);

    go(16'h0400, 16'd6);
    send(16'hE000, 0); send(16'hE001, 0); send(16'hE002, 0);
    itf.in_data = 16'hE003;
    itf.in_valid = 1;
    nreset = 0;
    tick(); tick();
    nreset = 1;
    itf.in_valid = 0;
    check("abort busy", itf.busy, 0);
    check("abort done", itf.done, 0);
    check("abort wr_en", itf.wr_en, 0);
    wlog.delete(); wcyc.delete();
    go(16'h0500, 16'd2);
    send(16'hF000, 0); send(16'hF001, 0);
    wait_done("after reset");
    check("after reset count", wlog.size(), 2);
    check("after reset addr", wlog[1], 16'h0501);
    check("after reset mem", mem[16'h0500], 16'hF000);

`ifdef READBACK_VERIFY_EN
    corrupt = 1;
    corrupt_addr = 16'h0601;
    go(16'h0600, 16'd3);
    for (int i = 0; i < 3; i++) send(16'h1230 + 16'(i), 0);
    wait_done("verify bad");
    check("verify error sticky", itf.error, 1);
    corrupt = 0;
    wlog.delete(); wcyc.delete();
    go(16'h0610, 16'd2);
    check("verify error cleared", itf.error, 0);
    send(16'h4560, 0); send(16'h4561, 0);
    wait_done("verify clean");
    check("verify clean error", itf.error, 0);
    check("verify spacing", wcyc[1] - wcyc[0], 3);
`endif

    tick();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
